// File: rtl/eco32f_decode_pkg.sv
// ECO32F decode-stage package.
// Holds the opcode map, the bubble instruction, the decoded-instruction and
// ID/EX register structures, and the pure instruction decode function used by
// eco32f_decode. No ports; imported with "import eco32f_decode_pkg::*".
package eco32f_decode_pkg;

  // add r0,r0,r0: the canonical bubble.
  localparam logic [31:0] ECO32F_INSN_NOP = 32'h0000_0000;

  // Opcode map (insn[31:26]).
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBI  = 6'h03;
  localparam logic [5:0] OP_MUL   = 6'h04;
  localparam logic [5:0] OP_MULI  = 6'h05;
  localparam logic [5:0] OP_MULU  = 6'h06;
  localparam logic [5:0] OP_MULUI = 6'h07;
  localparam logic [5:0] OP_DIV   = 6'h08;
  localparam logic [5:0] OP_DIVI  = 6'h09;
  localparam logic [5:0] OP_DIVU  = 6'h0A;
  localparam logic [5:0] OP_DIVUI = 6'h0B;
  localparam logic [5:0] OP_REM   = 6'h0C;
  localparam logic [5:0] OP_REMI  = 6'h0D;
  localparam logic [5:0] OP_REMU  = 6'h0E;
  localparam logic [5:0] OP_REMUI = 6'h0F;
  localparam logic [5:0] OP_AND   = 6'h10;
  localparam logic [5:0] OP_ANDI  = 6'h11;
  localparam logic [5:0] OP_OR    = 6'h12;
  localparam logic [5:0] OP_ORI   = 6'h13;
  localparam logic [5:0] OP_XOR   = 6'h14;
  localparam logic [5:0] OP_XORI  = 6'h15;
  localparam logic [5:0] OP_XNOR  = 6'h16;
  localparam logic [5:0] OP_XNORI = 6'h17;
  localparam logic [5:0] OP_SLL   = 6'h18;
  localparam logic [5:0] OP_SLLI  = 6'h19;
  localparam logic [5:0] OP_SLR   = 6'h1A;
  localparam logic [5:0] OP_SLRI  = 6'h1B;
  localparam logic [5:0] OP_SAR   = 6'h1C;
  localparam logic [5:0] OP_SARI  = 6'h1D;
  localparam logic [5:0] OP_ILL1E = 6'h1E;
  localparam logic [5:0] OP_LDHI  = 6'h1F;
  localparam logic [5:0] OP_BEQ   = 6'h20;
  localparam logic [5:0] OP_BGTU  = 6'h29;
  localparam logic [5:0] OP_J     = 6'h2A;
  localparam logic [5:0] OP_JR    = 6'h2B;
  localparam logic [5:0] OP_JAL   = 6'h2C;
  localparam logic [5:0] OP_JALR  = 6'h2D;
  localparam logic [5:0] OP_LDW   = 6'h30;
  localparam logic [5:0] OP_LDBU  = 6'h34;
  localparam logic [5:0] OP_STW   = 6'h35;
  localparam logic [5:0] OP_STB   = 6'h37;
  localparam logic [5:0] OP_MVFS  = 6'h38;
  localparam logic [5:0] OP_MVTS  = 6'h39;
  localparam logic [5:0] OP_ILL3E = 6'h3E;
  localparam logic [5:0] OP_ILL3F = 6'h3F;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Result of decoding one instruction word (no operand data).
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rf_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
  } dec_t;

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        rf_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        exc_ibus_fault;
    logic        exc_illegal;
  } ex_reg_t;

  function automatic dec_t decode_insn(input logic [31:0] insn);
    dec_t        d;
    logic [5:0]  op;
    logic [31:0] sext16;
    op     = insn[31:26];
    sext16 = {{16{insn[15]}}, insn[15:0]};
    d          = '0;
    d.imm      = {16'h0000, insn[15:0]};
    d.rs1_used = 1'b1;

    if (op < OP_ILL1E) begin
      d.rf_we = 1'b1;
      if (!op[0]) begin
        // Register-register form.
        d.rd       = insn[15:11];
        d.rs2_used = 1'b1;
      end else begin
        // Register-immediate form; only the signed arithmetic ops sign-extend.
        d.rd = insn[20:16];
        if (op inside {OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI, OP_REMI}) d.imm = sext16;
      end
    end else begin
      case (op) inside
        OP_LDHI: begin
          d.rd       = insn[20:16];
          d.rf_we    = 1'b1;
          d.imm      = {insn[15:0], 16'h0000};
          d.rs1_used = 1'b0;
        end
        [OP_BEQ:OP_BGTU]: begin
          d.is_branch = 1'b1;
          d.rs2_used  = 1'b1;
          d.imm       = {sext16[29:0], 2'b00};
        end
        OP_J, OP_JAL: begin
          d.is_branch = 1'b1;
          d.rs1_used  = 1'b0;
          d.imm       = {{4{insn[25]}}, insn[25:0], 2'b00};
          if (op == OP_JAL) begin
            d.rd    = LINK_REG;
            d.rf_we = 1'b1;
          end
        end
        OP_JR:   d.is_branch = 1'b1;
        OP_JALR: begin
          d.is_branch = 1'b1;
          d.rd        = LINK_REG;
          d.rf_we     = 1'b1;
        end
        [OP_LDW:OP_LDBU]: begin
          d.is_load = 1'b1;
          d.rd      = insn[20:16];
          d.rf_we   = 1'b1;
          d.imm     = sext16;
        end
        [OP_STW:OP_STB]: begin
          d.is_store = 1'b1;
          d.rs2_used = 1'b1;
          d.imm      = sext16;
        end
        OP_MVFS: begin
          d.rd       = insn[20:16];
          d.rf_we    = 1'b1;
          d.rs1_used = 1'b0;
        end
        OP_MVTS: d.rs2_used = 1'b1;
        OP_ILL1E, OP_ILL3E, OP_ILL3F: begin
          d.illegal  = 1'b1;
          d.rs1_used = 1'b0;
        end
        default: ;
      endcase
    end

    // r0 is never a real destination; illegal instructions never write.
    if (d.rd == 5'd0 || d.illegal) d.rf_we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/eco32f_decode_if.sv
// ID-stage connection bundle for eco32f_decode.
// Groups the fetch-side inputs (id_*), stall/flush controls, the fetch stall
// request, the write-back port (wb_*) and all ID/EX register outputs (ex_*).
// modport slave  : the decode stage (consumes id/wb, drives ex/if_stall_req).
// modport master : the surrounding pipeline (drives id/wb, consumes ex).
interface eco32f_decode_if;
  logic        id_stall;
  logic        id_flush;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic        id_exc_ibus_fault;
  logic        if_stall_req;

  logic        wb_rf_we;
  logic [4:0]  wb_rf_addr;
  logic [31:0] wb_rf_data;

  logic [31:0] ex_pc;
  logic [31:0] ex_insn;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic        ex_rf_we;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_is_branch;
  logic        ex_exc_ibus_fault;
  logic        ex_exc_illegal;

  modport master (
    output id_stall, id_flush, id_pc, id_insn, id_exc_ibus_fault,
    output wb_rf_we, wb_rf_addr, wb_rf_data,
    input  if_stall_req,
    input  ex_pc, ex_insn, ex_opcode, ex_rs1, ex_rs2, ex_rd,
    input  ex_rs1_data, ex_rs2_data, ex_imm, ex_rf_we,
    input  ex_is_load, ex_is_store, ex_is_branch,
    input  ex_exc_ibus_fault, ex_exc_illegal
  );

  modport slave (
    input  id_stall, id_flush, id_pc, id_insn, id_exc_ibus_fault,
    input  wb_rf_we, wb_rf_addr, wb_rf_data,
    output if_stall_req,
    output ex_pc, ex_insn, ex_opcode, ex_rs1, ex_rs2, ex_rd,
    output ex_rs1_data, ex_rs2_data, ex_imm, ex_rf_we,
    output ex_is_load, ex_is_store, ex_is_branch,
    output ex_exc_ibus_fault, ex_exc_illegal
  );
endinterface

// File: rtl/eco32f_regfile.sv
// ECO32F integer register file: 32 x 32 bits, two combinational read ports,
// one synchronous write port. r0 always reads zero and ignores writes. A write
// in flight is bypassed to a read of the same register in the same cycle.
// Ports: clk; we/waddr/wdata write port; raddr1/rdata1, raddr2/rdata2 reads.
module eco32f_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem [32];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  // NOTE: the storage array has no reset on purpose -- register contents are
  // architecturally undefined after reset, and a reset here would turn a RAM
  // into 1024 flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with non-blocking (<=).
    if (wr_en) mem[waddr] <= wdata;
  end

  // r0 is masked at the read side, so mem[0] is never consulted.
  assign rdata1 = (raddr1 == 5'd0)                 ? 32'h0 :
                  (wr_en && (waddr == raddr1))     ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0)                 ? 32'h0 :
                  (wr_en && (waddr == raddr2))     ? wdata : mem[raddr2];

endmodule

// File: rtl/eco32f_decode.sv
// ECO32F instruction decode stage.
// Decodes the instruction held in ID, reads both operands from the register
// file (with write-back bypass), builds the immediate, detects load-use
// hazards and registers the result into the ID/EX register.
// Ports: clk; rst (synchronous, active-high); pipe (eco32f_decode_if.slave):
//   id_* / id_stall / id_flush in, wb_* register-file write in,
//   if_stall_req out (load-use interlock), ex_* ID/EX register out.
// Parameter NOP_INSN: instruction word placed in EX for every bubble.
module eco32f_decode
  import eco32f_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = ECO32F_INSN_NOP
) (
  input  logic            clk,
  input  logic            rst,
  eco32f_decode_if.slave  pipe
);

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  dec_t        id_dec;
  logic        hz;
  ex_reg_t     ex_q;
  ex_reg_t     ex_d;
  ex_reg_t     ex_bubble;

  assign id_rs1 = pipe.id_insn[25:21];
  assign id_rs2 = pipe.id_insn[20:16];

  always_comb id_dec = decode_insn(pipe.id_insn);

  eco32f_regfile u_regfile (
    .clk    (clk),
    .we     (pipe.wb_rf_we),
    .waddr  (pipe.wb_rf_addr),
    .wdata  (pipe.wb_rf_data),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (id_rs1_data),
    .rdata2 (id_rs2_data)
  );

  // Load-use interlock: the load in EX has no data until MEM, so a consumer
  // in ID must wait one cycle. A flush or downstream stall supersedes it.
  assign hz = ex_q.is_load && ex_q.rf_we &&
              (((ex_q.rd == id_rs1) && id_dec.rs1_used) ||
               ((ex_q.rd == id_rs2) && id_dec.rs2_used));
  assign pipe.if_stall_req = hz && !pipe.id_flush && !pipe.id_stall;

  always_comb begin
    ex_bubble      = '0;
    ex_bubble.insn = NOP_INSN;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ex_d = ex_q;
    if (pipe.id_flush) begin
      ex_d = ex_bubble;
    end else if (pipe.id_stall) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d = ex_bubble;
    end else begin
      ex_d.pc             = pipe.id_pc;
      ex_d.insn           = pipe.id_insn;
      ex_d.rs1            = id_rs1;
      ex_d.rs2            = id_rs2;
      ex_d.rd             = id_dec.rd;
      ex_d.rs1_data       = id_rs1_data;
      ex_d.rs2_data       = id_rs2_data;
      ex_d.imm            = id_dec.imm;
      ex_d.exc_illegal    = id_dec.illegal;
      ex_d.exc_ibus_fault = pipe.id_exc_ibus_fault;
      // A faulted fetch carries no architectural effect past the fault flag.
      ex_d.rf_we          = id_dec.rf_we     && !pipe.id_exc_ibus_fault;
      ex_d.is_load        = id_dec.is_load   && !pipe.id_exc_ibus_fault;
      ex_d.is_store       = id_dec.is_store  && !pipe.id_exc_ibus_fault;
      ex_d.is_branch      = id_dec.is_branch && !pipe.id_exc_ibus_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= ex_bubble;
    else     ex_q <= ex_d;
  end

  assign pipe.ex_pc             = ex_q.pc;
  assign pipe.ex_insn           = ex_q.insn;
  assign pipe.ex_opcode         = ex_q.insn[31:26];
  assign pipe.ex_rs1            = ex_q.rs1;
  assign pipe.ex_rs2            = ex_q.rs2;
  assign pipe.ex_rd             = ex_q.rd;
  assign pipe.ex_rs1_data       = ex_q.rs1_data;
  assign pipe.ex_rs2_data       = ex_q.rs2_data;
  assign pipe.ex_imm            = ex_q.imm;
  assign pipe.ex_rf_we          = ex_q.rf_we;
  assign pipe.ex_is_load        = ex_q.is_load;
  assign pipe.ex_is_store       = ex_q.is_store;
  assign pipe.ex_is_branch      = ex_q.is_branch;
  assign pipe.ex_exc_ibus_fault = ex_q.exc_ibus_fault;
  assign pipe.ex_exc_illegal    = ex_q.exc_illegal;

endmodule

// File: tb/tb_eco32f_decode.sv
// Self-checking bench for eco32f_decode. Stimulus pushes the hand-computed
// ID/EX contents expected after each clock edge into a queue; a monitor pops
// and compares on the following falling edge.
module tb_eco32f_decode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eco32f_decode_if bus ();

  eco32f_decode dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        we;
    logic        ld;
    logic        st;
    logic        br;
    logic        flt;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, insn, input logic [4:0] rd,
                              input logic [31:0] d1, d2, imm,
                              input logic we, ld, st, br, flt, ill);
    exp_t e;
    e.pc = pc; e.insn = insn; e.rd = rd; e.d1 = d1; e.d2 = d2; e.imm = imm;
    e.we = we; e.ld = ld; e.st = st; e.br = br; e.flt = flt; e.ill = ill;
    return e;
  endfunction

  exp_t bub;
  initial bub = mk(32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);

  // Monitor: the EX register presents a new value every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("ex_pc@%h", e.pc),          bus.ex_pc,             e.pc);
      check($sformatf("ex_insn@%h", e.pc),        bus.ex_insn,           e.insn);
      check($sformatf("ex_opcode@%h", e.pc),      bus.ex_opcode,         e.insn[31:26]);
      check($sformatf("ex_rs1@%h", e.pc),         bus.ex_rs1,            e.insn[25:21]);
      check($sformatf("ex_rs2@%h", e.pc),         bus.ex_rs2,            e.insn[20:16]);
      check($sformatf("ex_rd@%h", e.pc),          bus.ex_rd,             e.rd);
      check($sformatf("ex_rs1_data@%h", e.pc),    bus.ex_rs1_data,       e.d1);
      check($sformatf("ex_rs2_data@%h", e.pc),    bus.ex_rs2_data,       e.d2);
      check($sformatf("ex_imm@%h", e.pc),         bus.ex_imm,            e.imm);
      check($sformatf("ex_rf_we@%h", e.pc),       bus.ex_rf_we,          e.we);
      check($sformatf("ex_is_load@%h", e.pc),     bus.ex_is_load,        e.ld);
      check($sformatf("ex_is_store@%h", e.pc),    bus.ex_is_store,       e.st);
      check($sformatf("ex_is_branch@%h", e.pc),   bus.ex_is_branch,      e.br);
      check($sformatf("ex_exc_ibus@%h", e.pc),    bus.ex_exc_ibus_fault, e.flt);
      check($sformatf("ex_exc_illegal@%h", e.pc), bus.ex_exc_illegal,    e.ill);
    end
  end

  task automatic id(input logic [31:0] pc, input logic [31:0] insn, input logic flt);
    bus.id_pc = pc; bus.id_insn = insn; bus.id_exc_ibus_fault = flt;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_rf_we = we; bus.wb_rf_addr = addr; bus.wb_rf_data = data;
  endtask

  task automatic chk_sreq(input logic v);
    #1 check($sformatf("if_stall_req@%h", bus.id_pc), bus.if_stall_req, v);
  endtask

  // One clock: expected EX contents after this edge go to the scoreboard.
  task automatic tick(input exp_t e);
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] ADD_3_1_2  = 32'h0022_1800;
  localparam logic [31:0] LDW_4_1_0  = 32'hC024_0000;
  localparam logic [31:0] ADD_5_4_2  = 32'h0082_2800;
  localparam logic [31:0] ADD_3_0_0  = 32'h0000_1800;

  initial begin
    rst = 1'b1;
    bus.id_stall = 1'b0;
    bus.id_flush = 1'b0;
    id(32'h0, 32'h0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    tick(bub);
    tick(bub);
    rst = 1'b0;

    // Preload operands through the write-back port while ID holds the NOP.
    wb(1'b1, 5'd1, 32'd5);      tick(bub);
    wb(1'b1, 5'd2, 32'd7);      tick(bub);
    wb(1'b1, 5'd4, 32'h44);     tick(bub);
    wb(1'b1, 5'd6, 32'h66);     tick(bub);
    wb(1'b0, 5'd0, 32'h0);

    // add r3,r1,r2
    id(32'h100, ADD_3_1_2, 1'b0); chk_sreq(1'b0);
    tick(mk(32'h100, ADD_3_1_2, 5'd3, 32'd5, 32'd7, 32'h1800, 1, 0, 0, 0, 0, 0));

    // ldw r4,r1,0 followed by add r5,r4,r2: one bubble, then the add.
    id(32'h104, LDW_4_1_0, 1'b0); chk_sreq(1'b0);
    tick(mk(32'h104, LDW_4_1_0, 5'd4, 32'd5, 32'h44, 32'h0, 1, 1, 0, 0, 0, 0));
    id(32'h108, ADD_5_4_2, 1'b0); chk_sreq(1'b1);
    tick(bub);
    chk_sreq(1'b0);
    tick(mk(32'h108, ADD_5_4_2, 5'd5, 32'h44, 32'd7, 32'h2800, 1, 0, 0, 0, 0, 0));

    // Write-back of r2 in the same cycle ID reads it.
    id(32'h10C, ADD_3_1_2, 1'b0); wb(1'b1, 5'd2, 32'hDEADBEEF);
    tick(mk(32'h10C, ADD_3_1_2, 5'd3, 32'd5, 32'hDEADBEEF, 32'h1800, 1, 0, 0, 0, 0, 0));
    wb(1'b0, 5'd0, 32'h0);

    // Immediate forms: andi, addi, ldhi.
    id(32'h110, 32'h4426_8000, 1'b0);
    tick(mk(32'h110, 32'h4426_8000, 5'd6, 32'd5, 32'h66, 32'h0000_8000, 1, 0, 0, 0, 0, 0));
    id(32'h114, 32'h0426_8000, 1'b0);
    tick(mk(32'h114, 32'h0426_8000, 5'd6, 32'd5, 32'h66, 32'hFFFF_8000, 1, 0, 0, 0, 0, 0));
    id(32'h118, 32'h7C06_1234, 1'b0);
    tick(mk(32'h118, 32'h7C06_1234, 5'd6, 32'h0, 32'h66, 32'h1234_0000, 1, 0, 0, 0, 0, 0));

    // Downstream stall for three cycles: EX frozen on the ldhi.
    bus.id_stall = 1'b1;
    id(32'h200, ADD_3_1_2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_sreq(1'b0);
      tick(mk(32'h118, 32'h7C06_1234, 5'd6, 32'h0, 32'h66, 32'h1234_0000, 1, 0, 0, 0, 0, 0));
    end
    bus.id_stall = 1'b0;

    // Flush while a load-use hazard is pending.
    id(32'h11C, LDW_4_1_0, 1'b0);
    tick(mk(32'h11C, LDW_4_1_0, 5'd4, 32'd5, 32'h44, 32'h0, 1, 1, 0, 0, 0, 0));
    id(32'h120, ADD_5_4_2, 1'b0); bus.id_flush = 1'b1; chk_sreq(1'b0);
    tick(bub);
    bus.id_flush = 1'b0;
    id(32'h0, 32'h0, 1'b0);
    tick(bub);

    // Illegal opcode 0x3F.
    id(32'h124, 32'hFC00_0000, 1'b0);
    tick(mk(32'h124, 32'hFC00_0000, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));

    // Fetch bus fault on an add and on a load; the faulted load cannot interlock.
    id(32'h128, ADD_3_1_2, 1'b1);
    tick(mk(32'h128, ADD_3_1_2, 5'd3, 32'd5, 32'hDEADBEEF, 32'h1800, 0, 0, 0, 0, 1, 0));
    id(32'h12C, LDW_4_1_0, 1'b1);
    tick(mk(32'h12C, LDW_4_1_0, 5'd4, 32'd5, 32'h44, 32'h0, 0, 0, 0, 0, 1, 0));
    id(32'h130, ADD_5_4_2, 1'b0); chk_sreq(1'b0);
    tick(mk(32'h130, ADD_5_4_2, 5'd5, 32'h44, 32'hDEADBEEF, 32'h2800, 1, 0, 0, 0, 0, 0));

    // Writes to r0 are neither bypassed nor stored.
    id(32'h134, ADD_3_0_0, 1'b0); wb(1'b1, 5'd0, 32'h0000_0123);
    tick(mk(32'h134, ADD_3_0_0, 5'd3, 32'h0, 32'h0, 32'h1800, 1, 0, 0, 0, 0, 0));
    wb(1'b0, 5'd0, 32'h0);
    id(32'h138, ADD_3_0_0, 1'b0);
    tick(mk(32'h138, ADD_3_0_0, 5'd3, 32'h0, 32'h0, 32'h1800, 1, 0, 0, 0, 0, 0));

    // beq r1,r2,-1 ; jal 0x10 ; stw r2,r1,4
    id(32'h13C, 32'h8022_FFFF, 1'b0);
    tick(mk(32'h13C, 32'h8022_FFFF, 5'd0, 32'd5, 32'hDEADBEEF, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0));
    id(32'h140, 32'hB000_0010, 1'b0);
    tick(mk(32'h140, 32'hB000_0010, 5'd31, 32'h0, 32'h0, 32'h0000_0040, 1, 0, 0, 1, 0, 0));
    id(32'h144, 32'hD422_0004, 1'b0);
    tick(mk(32'h144, 32'hD422_0004, 5'd0, 32'd5, 32'hDEADBEEF, 32'h0000_0004, 0, 0, 1, 0, 0, 0));

    // Reset mid-operation bubbles EX; register contents survive it.
    id(32'h148, ADD_3_1_2, 1'b0); rst = 1'b1;
    tick(bub);
    rst = 1'b0;
    tick(mk(32'h148, ADD_3_1_2, 5'd3, 32'd5, 32'hDEADBEEF, 32'h1800, 1, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
